cpu_core: RTL and testbench

Single-cycle 8-bit processor core. It presents a 32-bit byte-address program counter to an external combinational instruction memory. It executes the returned 32-bit instruction in one clock cycle and commits the register write and the PC update on the next rising clock edge. It contains the PC logic, an 8×8-bit register file, the decoder, the ALU/shifter and the branch unit. Data memory is not part of this block.

---
 rtl/cpu_core.sv | 128 ++++++++++++
 tb/tb_cpu_core.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - single-cycle 8-bit core: PC, 8x8 register file, decoder, ALU/shifter, branch unit
// Optional multiplier for opcode 0x09 enabled by defining CPU_MULT_EN.
module cpu_core (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] PC,
    input  logic [31:0] INSTRUCTION
);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_SRA   = 8'h08;
    localparam logic [7:0] OP_MULT  = 8'h09;
    localparam logic [7:0] OP_SLL   = 8'h0A;
    localparam logic [7:0] OP_SRL   = 8'h0B;
    localparam logic [7:0] OP_ROR   = 8'h0C;
    localparam logic [7:0] OP_BNE   = 8'h0F;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [7:0]  rf_q [8];
    logic        we_d;
    logic [7:0]  wdata_d;

    logic [7:0]  opcode;
    logic [7:0]  offset;
    logic [7:0]  imm;
    logic [2:0]  rd_idx;
    logic [2:0]  rt_idx;
    logic [2:0]  rs_idx;
    logic [7:0]  rt_val;
    logic [7:0]  rs_val;
    logic [31:0] pc4;
    logic [31:0] target;
    logic [7:0]  sra_val;
    logic [7:0]  sll_val;
    logic [7:0]  srl_val;
    logic [15:0] rot_wide;
    logic [7:0]  ror_val;
    logic        unused_bits;

    assign opcode = INSTRUCTION[31:24];
    assign offset = INSTRUCTION[23:16];
    assign imm    = INSTRUCTION[7:0];
    assign rd_idx = INSTRUCTION[18:16];
    assign rt_idx = INSTRUCTION[10:8];
    assign rs_idx = INSTRUCTION[2:0];
    assign unused_bits = ^INSTRUCTION[15:11];

    assign rt_val = rf_q[rt_idx];
    assign rs_val = rf_q[rs_idx];

    // OFFSET counts instructions, so it is scaled to bytes before the add.
    assign pc4    = pc_q + 32'd4;
    assign target = pc4 + {{22{offset[7]}}, offset, 2'b00};

    always_comb begin
        sra_val  = 8'h00;
        sll_val  = 8'h00;
        srl_val  = 8'h00;
        rot_wide = {rt_val, rt_val} >> imm[2:0];
        ror_val  = rot_wide[7:0];
        if (imm >= 8'd7) begin
            sra_val = {8{rt_val[7]}};
        end else begin
            sra_val = $signed(rt_val) >>> imm[2:0];
        end
        if (imm < 8'd8) begin
            sll_val = rt_val << imm[2:0];
            srl_val = rt_val >> imm[2:0];
        end
    end

`ifdef CPU_MULT_EN
    logic [7:0] mult_val;
    assign mult_val = rt_val * rs_val;
`endif

    always_comb begin
        we_d    = 1'b0;
        wdata_d = 8'h00;
        pc_d    = pc4;
        case (opcode)
            OP_LOADI: begin we_d = 1'b1; wdata_d = imm;             end
            OP_MOV:   begin we_d = 1'b1; wdata_d = rs_val;          end
            OP_ADD:   begin we_d = 1'b1; wdata_d = rt_val + rs_val; end
            OP_SUB:   begin we_d = 1'b1; wdata_d = rt_val - rs_val; end
            OP_AND:   begin we_d = 1'b1; wdata_d = rt_val & rs_val; end
            OP_OR:    begin we_d = 1'b1; wdata_d = rt_val | rs_val; end
            OP_J:     pc_d = target;
            OP_BEQ:   if (rt_val == rs_val) pc_d = target;
            OP_BNE:   if (rt_val != rs_val) pc_d = target;
            OP_SRA:   begin we_d = 1'b1; wdata_d = sra_val;         end
            OP_SLL:   begin we_d = 1'b1; wdata_d = sll_val;         end
            OP_SRL:   begin we_d = 1'b1; wdata_d = srl_val;         end
            OP_ROR:   begin we_d = 1'b1; wdata_d = ror_val;         end
`ifdef CPU_MULT_EN
            OP_MULT:  begin we_d = 1'b1; wdata_d = mult_val;        end
`else
            OP_MULT:  pc_d = pc4;
`endif
            default:  pc_d = pc4;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q <= 32'h0000_0000;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            pc_q <= pc_d;
            if (we_d) begin
                rf_q[rd_idx] <= wdata_d;
            end
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - directed scoreboard bench for cpu_core
module tb_cpu_core;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic [31:0] imem [0:63];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    cpu_core dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .INSTRUCTION (INSTRUCTION)
    );

    always #5 CLK = ~CLK;

    assign INSTRUCTION = imem[PC[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input int idx, input logic [7:0] val);
        check($sformatf("r%0d", idx), {24'h0, dut.rf_q[idx[2:0]]}, {24'h0, val});
    endtask

    task automatic run_edges(input int n);
        logic [31:0] e;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed=%h expected=none", PC);
            end else begin
                e = exp_q.pop_front();
                check("pc", PC, e);
            end
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
    endtask

    initial begin
        clear_imem();
        imem[0] = 32'h0004_000A;
        imem[1] = 32'h0005_00EA;
        imem[2] = 32'h0A06_0402;
        imem[3] = 32'h0B07_0502;
        imem[4] = 32'h0FFE_0607;

        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_pc", PC, 32'h0);
        for (int i = 0; i < 8; i++) check_reg(i, 8'h00);

        @(negedge CLK);
        RESET = 1'b1;
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd16);
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd16);
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd16);
        run_edges(8);
        check_reg(4, 8'h0A);
        check_reg(5, 8'hEA);
        check_reg(6, 8'h28);
        check_reg(7, 8'h3A);

        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("async_reset_pc", PC, 32'h0);
        for (int i = 0; i < 8; i++) check_reg(i, 8'h00);

        clear_imem();
        imem[0]  = 32'h0001_0005;
        imem[1]  = 32'h0002_0005;
        imem[2]  = 32'h0303_0102;
        imem[3]  = 32'h0701_0102;
        imem[4]  = 32'h0003_0077;
        imem[5]  = 32'h0001_00FF;
        imem[6]  = 32'h0002_0002;
        imem[7]  = 32'h0203_0102;
        imem[8]  = 32'h0001_0080;
        imem[9]  = 32'h0804_0103;
        imem[10] = 32'h0005_0055;
        imem[11] = 32'h0A05_0208;
        imem[12] = 32'h0006_0001;
        imem[13] = 32'h0C07_0609;
        imem[14] = 32'h0001_0010;
        imem[15] = 32'h0002_0011;
        imem[16] = 32'h0000_005A;
        imem[17] = 32'h0900_0102;
        imem[18] = 32'h06ED_0000;

        @(negedge CLK);
        RESET = 1'b1;
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd12);
        run_edges(3);
        check_reg(1, 8'h05);
        check_reg(2, 8'h05);
        check_reg(3, 8'h00);

        exp_q.push_back(32'd20);
        for (int a = 24; a <= 72; a += 4) exp_q.push_back(a);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        run_edges(16);
        check_reg(1, 8'h05);
        check_reg(2, 8'h11);
        check_reg(3, 8'h01);
        check_reg(4, 8'hF0);
        check_reg(5, 8'h00);
        check_reg(6, 8'h01);
        check_reg(7, 8'h80);
`ifdef CPU_MULT_EN
        check_reg(0, 8'h10);
`else
        check_reg(0, 8'h5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
